// File: rtl/ld_st_shreg_ctl.sv
// ld_st_shreg_ctl: WIDTH-bit universal shift register (hold / load / shift
// left / shift right) with an autonomous WIDTH-shift burst engine and a
// busy/done handshake. Serves as the SERDES stage between parallel registers
// and 1-bit serial links.
//
// Optional build macro: SHREG_ROTATE_EN
//   defined   -> rot=1 recirculates the shifted-out bit into the vacated end
//   undefined -> rot is ignored; sl_in/sr_in always feed the vacated end
module ld_st_shreg_ctl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             set,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d_in,
    input  logic             sl_in,
    input  logic             sr_in,
    input  logic             start,
    input  logic             dir,
    input  logic             rot,
    output logic [WIDTH-1:0] q,
    output logic             sl_out,
    output logic             sr_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             dir_r, dir_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             rot_s;

    // Shift toward the MSB; the vacated LSB takes the serial input or, when
    // rotating, the MSB that falls off the top.
    function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                    input logic sin,
                                                    input logic rot_en);
        logic fill;
        fill = rot_en ? v[WIDTH-1] : sin;
        return {v[WIDTH-2:0], fill};
    endfunction

    // Shift toward the LSB; the vacated MSB takes the serial input or, when
    // rotating, the LSB that falls off the bottom.
    function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                     input logic sin,
                                                     input logic rot_en);
        logic fill;
        fill = rot_en ? v[0] : sin;
        return {fill, v[WIDTH-1:1]};
    endfunction

`ifdef SHREG_ROTATE_EN
    assign rot_s = rot;
`else
    // rot stays on the port so both builds share one interface; it is
    // deliberately sunk here and has no effect.
    logic unused_rot_s;
    assign unused_rot_s = rot;
    assign rot_s        = 1'b0;
`endif

    // Next-state, next-data and handshake decode; set outranks everything.
    always_comb begin
        state_s = state_r;
        q_s     = q_r;
        cnt_s   = cnt_r;
        dir_s   = dir_r;
        if (set) begin
            q_s     = {WIDTH{1'b1}};
            state_s = ST_IDLE;
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        // Accepting edge: latch direction, q untouched.
                        state_s = ST_SHIFT;
                        dir_s   = dir;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        case (mode)
                            2'b00:   q_s = q_r;
                            2'b01:   q_s = d_in;
                            2'b10:   q_s = shift_left(q_r, sl_in, rot_s);
                            2'b11:   q_s = shift_right(q_r, sr_in, rot_s);
                            default: q_s = q_r;
                        endcase
                    end
                end
                ST_SHIFT: begin
                    if (dir_r) begin
                        q_s = shift_right(q_r, sr_in, rot_s);
                    end else begin
                        q_s = shift_left(q_r, sl_in, rot_s);
                    end
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    // cnt saturates at WIDTH because the last shift leaves SHIFT.
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    // One-cycle completion slot; start is ignored here.
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
        busy_s = (state_s == ST_SHIFT);
        done_s = (state_s == ST_DONE);
    end

    // State, data and registered handshake flags; clr clears asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
            q_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            dir_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            q_r     <= q_s;
            cnt_r   <= cnt_s;
            dir_r   <= dir_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign q      = q_r;
    assign sl_out = q_r[WIDTH-1];
    assign sr_out = q_r[0];
    assign busy   = busy_r;
    assign done   = done_r;
    assign cnt    = cnt_r;

endmodule

// File: tb/tb_ld_st_shreg_ctl.sv
// Directed self-checking bench for ld_st_shreg_ctl (WIDTH=8, CNT_W=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ld_st_shreg_ctl;

    logic       clk;
    logic       clr;
    logic       set;
    logic [1:0] mode;
    logic [7:0] d_in;
    logic       sl_in;
    logic       sr_in;
    logic       start;
    logic       dir;
    logic       rot;
    logic [7:0] q;
    logic       sl_out;
    logic       sr_out;
    logic       busy;
    logic       done;
    logic [3:0] cnt;

    int n_vec;
    int n_miss;

    ld_st_shreg_ctl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk    (clk),
        .clr    (clr),
        .set    (set),
        .mode   (mode),
        .d_in   (d_in),
        .sl_in  (sl_in),
        .sr_in  (sr_in),
        .start  (start),
        .dir    (dir),
        .rot    (rot),
        .q      (q),
        .sl_out (sl_out),
        .sr_out (sr_out),
        .busy   (busy),
        .done   (done),
        .cnt    (cnt)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        mode = 2'b01;
        d_in = v;
        step();
        mode = 2'b00;
    endtask

    logic [7:0] pat;
    logic [7:0] rsr;
    logic [7:0] exp_q;

    initial begin
        n_vec  = 0;
        n_miss = 0;
        clr = 1'b1; set = 1'b0; mode = 2'b00; d_in = 8'h00;
        sl_in = 1'b0; sr_in = 1'b0; start = 1'b0; dir = 1'b0; rot = 1'b0;

        // Reset state
        #12;
        check_val("rst_q", {24'd0, q}, 32'h00);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_cnt", {28'd0, cnt}, 32'd0);
        clr = 1'b0;

        // Asynchronous clear mid-cycle
        load(8'hA5);
        check_val("load_a5", {24'd0, q}, 32'hA5);
        #2 clr = 1'b1;
        #1;
        check_val("aclr_q", {24'd0, q}, 32'h00);
        check_val("aclr_busy", {31'd0, busy}, 32'd0);
        check_val("aclr_done", {31'd0, done}, 32'd0);
        mode = 2'b01; d_in = 8'hFF;
        step();
        check_val("clr_hold_edge", {24'd0, q}, 32'h00);
        #2 clr = 1'b0;
        mode = 2'b00;

        // Load then hold for 5 cycles
        load(8'h3C);
        check_val("load_3c", {24'd0, q}, 32'h3C);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("hold_3c", {24'd0, q}, 32'h3C);
        end

        // Mode-driven shifts while idle
        mode = 2'b10; sl_in = 1'b1;
        step();
        check_val("mode_shl", {24'd0, q}, 32'h79);
        mode = 2'b11; sr_in = 1'b1;
        step();
        check_val("mode_shr", {24'd0, q}, 32'hBC);
        mode = 2'b00; sl_in = 1'b0; sr_in = 1'b0;

        // Left burst serialising 8'hB1 MSB first; mode driven to prove it is ignored
        load(8'hB1);
        pat = 8'hB1;
        dir = 1'b0; start = 1'b1;
        step();
        start = 1'b0; mode = 2'b01; d_in = 8'hFF;
        check_val("lb_cnt0", {28'd0, cnt}, 32'd0);
        check_val("lb_q_unshifted", {24'd0, q}, 32'hB1);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) step();
            check_val("lb_sl_out", {31'd0, sl_out}, {31'd0, pat[8-k]});
            check_val("lb_busy", {31'd0, busy}, 32'd1);
            check_val("lb_done_low", {31'd0, done}, 32'd0);
        end
        step();
        check_val("lb_done", {31'd0, done}, 32'd1);
        check_val("lb_busy_end", {31'd0, busy}, 32'd0);
        check_val("lb_q_end", {24'd0, q}, 32'h00);
        check_val("lb_cnt_end", {28'd0, cnt}, 32'd8);
        start = 1'b1;
        step();
        start = 1'b0; mode = 2'b00;
        check_val("lb_done_pulse", {31'd0, done}, 32'd0);
        check_val("lb_start_in_done", {31'd0, busy}, 32'd0);
        check_val("lb_q_held", {24'd0, q}, 32'h00);
        check_val("lb_cnt_hold", {28'd0, cnt}, 32'd8);

        // Right burst deserialising sr_in = 1,1,0,0,1,0,1,0
        load(8'h00);
        rsr = 8'b0101_0011;
        dir = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sr_in = rsr[i];
            step();
            check_val("rb_cnt", {28'd0, cnt}, i + 1);
        end
        sr_in = 1'b0;
        check_val("rb_q", {24'd0, q}, 32'h53);
        check_val("rb_done", {31'd0, done}, 32'd1);
        step();

        // set during the 4th shift aborts the burst
        load(8'h0F);
        dir = 1'b0; sl_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_val("ab_cnt3", {28'd0, cnt}, 32'd3);
        check_val("ab_q3", {24'd0, q}, 32'h78);
        set = 1'b1;
        step();
        set = 1'b0;
        check_val("ab_q", {24'd0, q}, 32'hFF);
        check_val("ab_busy", {31'd0, busy}, 32'd0);
        check_val("ab_done", {31'd0, done}, 32'd0);
        check_val("ab_cnt", {28'd0, cnt}, 32'd0);
        step();
        check_val("ab_no_done", {31'd0, done}, 32'd0);
        check_val("ab_idle_hold", {24'd0, q}, 32'hFF);
        dir = 1'b1; sr_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check_val("ab_restart_busy", {31'd0, busy}, 32'd1);
        check_val("ab_restart_cnt", {28'd0, cnt}, 32'd0);
        step();
        check_val("ab_restart_q", {24'd0, q}, 32'h7F);
        check_val("ab_restart_cnt1", {28'd0, cnt}, 32'd1);
        for (int i = 0; i < 7; i++) step();
        check_val("ab_restart_done", {31'd0, done}, 32'd1);
        check_val("ab_restart_qend", {24'd0, q}, 32'h00);
        step();

        // Rotate select: burst and mode-driven shift
        load(8'h81);
        rot = 1'b1; sl_in = 1'b0; sr_in = 1'b0; dir = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
`ifdef SHREG_ROTATE_EN
        exp_q = 8'h81;
`else
        exp_q = 8'h00;
`endif
        check_val("rot_burst_q", {24'd0, q}, {24'd0, exp_q});
        check_val("rot_burst_done", {31'd0, done}, 32'd1);
        step();
        load(8'h01);
        mode = 2'b11;
        step();
        mode = 2'b00;
`ifdef SHREG_ROTATE_EN
        exp_q = 8'h80;
`else
        exp_q = 8'h00;
`endif
        check_val("rot_mode_shr", {24'd0, q}, {24'd0, exp_q});
        rot = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ld_st_shreg_ctl.md
Name: ld_st_shreg_ctl

Overview:
- Parametrised successor to the 1-bit load/store serial cell: a WIDTH-bit universal register supporting hold, parallel load, shift left and shift right.
- Adds an autonomous burst engine: a `start` pulse shifts the register exactly WIDTH times in the selected direction, with busy/done handshake.
- Used as the serialiser/deserialiser stage between parallel datapath registers and 1-bit serial links in the DV lab designs.

Parameters:
- WIDTH, 8, register width in bits; legal 2..32.
- CNT_W, 4, burst counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-high reset; clears all state.
- set  input  1  synchronous active-high preset; q <= all ones, aborts any burst.
- mode  input  2  00 hold, 01 parallel load, 10 shift left, 11 shift right.
- d_in  input  WIDTH  parallel load data.
- sl_in  input  1  serial input entering the LSB on a left shift.
- sr_in  input  1  serial input entering the MSB on a right shift.
- start  input  1  burst request; sampled only in IDLE.
- dir  input  1  burst direction: 0 left, 1 right; sampled with start.
- rot  input  1  rotate select; functional only with SHREG_ROTATE_EN.
- q  output  WIDTH  register contents.
- sl_out  output  1  q[WIDTH-1], combinational from q.
- sr_out  output  1  q[0], combinational from q.
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle pulse at burst end.
- cnt  output  CNT_W  shifts completed in the current burst.

Behaviour:
- Reset (clr=1, async): q=0, state=IDLE, cnt=0, busy=0, done=0. Effective immediately, independent of clk; no clock edge applied while clr is high changes state.
- Priority per clock edge: set > active burst > start > mode.
- set=1: q <= {WIDTH{1'b1}}, state <= IDLE, cnt <= 0, done <= 0. Applies mid-burst; the burst is aborted with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE to SHIFT: start=1 and set=0 at an edge. Latch dir, cnt <= 0, busy=1 from the next cycle. q is not shifted on the accepting edge. mode is ignored on that edge.
- SHIFT: each edge shifts q one place in the latched direction and increments cnt. mode and start are ignored.
  - Left: q <= {q[WIDTH-2:0], sl_in}.
  - Right: q <= {sr_in, q[WIDTH-1:1]}.
  - When cnt reaches WIDTH (i.e. the WIDTH-th shift has occurred), go to DONE.
- DONE: lasts exactly one cycle with done=1, busy=0, q held, cnt=WIDTH; then go to IDLE. A start seen in DONE is ignored.
- IDLE with no start: mode controls q.
  - 00: hold.
  - 01: q <= d_in.
  - 10: shift left as above.
  - 11: shift right as above.
  - cnt holds its last value until the next start.
- Total burst latency: start edge to done high = WIDTH+1 edges.
- sl_out and sr_out always reflect the current q. During a left burst the transmitted MSB-first stream appears on sl_out; during a right burst the LSB-first stream appears on sr_out.
- cnt never exceeds WIDTH and never wraps.

Optional Feature:
- Macro SHREG_ROTATE_EN.
- Defined: when rot=1, a shift (mode-driven or burst) feeds the bit shifted out back into the vacated end instead of sl_in/sr_in. After a full burst with rot=1, q equals its pre-burst value.
- Undefined: rot is ignored and serial inputs are always used. The port remains present so the interface is identical in both builds.

Test Plan:
- Reset: assert clr mid-cycle with q=8'hA5 -> q=0, busy=0, done=0 immediately, without waiting for a clock edge.
- Load/hold: mode=01, d_in=8'h3C for one edge, then mode=00 -> q=8'h3C and stable for 5 cycles.
- Left burst: q=8'hB1, dir=0, sl_in=0, pulse start -> sl_out emits 1,0,1,1,0,0,0,1 over 8 cycles; q=8'h00; done high exactly at edge 9; busy high for 8 cycles.
- Right burst deserialise: q=0, dir=1, sr_in driven 1,1,0,0,1,0,1,0 on successive SHIFT edges -> q=8'h53 at done.
- set mid-burst: set=1 at shift 4 -> q=8'hFF, busy=0, no done pulse; a later start begins a fresh burst with cnt=0.
- Rotate (SHREG_ROTATE_EN defined): q=8'h81, rot=1, left burst -> q=8'h81 at done. Same stimulus with the macro undefined and sl_in=0 -> q=8'h00.
